// File: rtl/packet_parser_gen.sv
// Header-stack parser: captures the leading bytes of a word-streamed packet, then
// walks Ethernet/VLAN/IPv4/L4/GTP-U/PDU/inner IPv4/L4 one header per cycle.
module packet_parser_gen #(
    parameter int BUS_W     = 32,
    parameter int HDR_BYTES = 128,
    parameter int VLAN_MAX  = 2,
    parameter int GTP_PORT  = 2152
) (
    input  logic                        CLK,
    input  logic                        reset,
    input  logic [BUS_W-1:0]            bus,
    input  logic                        bus_valid_i,
    input  logic                        start_of_packet_i,
    input  logic                        end_of_packet_i,
    input  logic [$clog2(BUS_W/8)-1:0]  eop_bytes_i,
    output logic                        bus_ready_o,
    output logic [15:0]                 phs_o,
    output logic                        phs_valid_o,
    output logic [15:0]                 pay_off_o,
    output logic [15:0]                 pkt_len_o,
    output logic [2:0]                  err_o,
    output logic [BUS_W-1:0]            pay_last_word
);
    localparam int BYTES = BUS_W / 8;
    localparam int EB_W  = $clog2(BYTES);
    localparam int AW    = $clog2(HDR_BYTES);

    typedef enum logic [3:0] {
        S_CAP, S_LOAD, S_ETH, S_VLAN, S_IPV4, S_L4, S_GTP, S_GTP_OPT,
        S_PDU, S_IN_IPV4, S_IN_L4, S_DONE
    } state_t;

    state_t      st;
    logic        cap_act;
    logic        gtp_e;
    logic [15:0] waddr, len, lim, off, stk;
    logic [2:0]  err;
    logic [7:0]  vc, proto;
    logic [7:0]  hbuf [HDR_BYTES];

    logic              accept, wen;
    logic [15:0]       wbase, nbytes;
    logic [16:0]       len_sum;
    logic [BUS_W-1:0]  masked;
    logic [7:0]        b0, b2, b3, b9, b12, b13, pdu_nx, tpdu;
    logic [15:0]       ihl_len, tcp_len, pdu_len, et, eth_len;
    logic              inner;

    function automatic logic [7:0] rd(input logic [15:0] idx);
        if (idx < 16'(HDR_BYTES)) return hbuf[idx[AW-1:0]];
        return 8'd0;
    endfunction

    // A header of n bytes starting at off is usable only if it ends before lim.
    function automatic logic fits(input logic [15:0] n);
        return ({1'b0, off} + {1'b0, n}) <= {1'b0, lim};
    endfunction

    always_comb begin
        accept  = bus_valid_i && bus_ready_o;
        wen     = accept && (start_of_packet_i || cap_act);
        wbase   = start_of_packet_i ? 16'd0 : waddr;
        nbytes  = (end_of_packet_i && eop_bytes_i != '0) ? 16'(eop_bytes_i) : 16'(BYTES);
        len_sum = {1'b0, (start_of_packet_i ? 16'd0 : len)} + {1'b0, nbytes};
        masked  = '0;
        for (int i = 0; i < BYTES; i++)
            if (eop_bytes_i == '0 || EB_W'(i) < eop_bytes_i)
                masked[BUS_W-1-8*i -: 8] = bus[BUS_W-1-8*i -: 8];
    end

    always_comb begin
        b0      = rd(off);
        b2      = rd(off + 16'd2);
        b3      = rd(off + 16'd3);
        b9      = rd(off + 16'd9);
        b12     = rd(off + 16'd12);
        b13     = rd(off + 16'd13);
        ihl_len = {10'd0, b0[3:0], 2'b00};
        tcp_len = {10'd0, b12[7:4], 2'b00};
        pdu_len = {6'd0, b0, 2'b00};
        pdu_nx  = rd(off + pdu_len - 16'd1);
        tpdu    = rd(off + pdu_len);
        et      = (st == S_ETH) ? {b12, b13} : {b2, b3};
        eth_len = (st == S_ETH) ? 16'd14 : 16'd4;
        inner   = (st == S_IN_IPV4) || (st == S_IN_L4);
    end

    // Capture buffer holds only packet data, so it carries no reset.
    always_ff @(posedge CLK) begin
        if (wen)
            for (int i = 0; i < BYTES; i++)
                if (int'(wbase) + i < HDR_BYTES)
                    hbuf[AW'(int'(wbase) + i)] <= bus[BUS_W-1-8*i -: 8];
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            st <= S_CAP;  cap_act <= 1'b0;  gtp_e <= 1'b0;
            waddr <= '0;  len <= '0;  lim <= '0;  off <= '0;  stk <= '0;
            err <= '0;  vc <= '0;  proto <= '0;
            bus_ready_o <= 1'b1;  phs_o <= '0;  phs_valid_o <= 1'b0;
            pay_off_o <= '0;  pkt_len_o <= '0;  err_o <= '0;  pay_last_word <= '0;
        end else begin
            phs_valid_o <= 1'b0;
            case (st)
                S_CAP: begin
                    bus_ready_o <= 1'b1;
                    if (wen) begin
                        cap_act <= !end_of_packet_i;
                        waddr   <= (wbase < 16'(HDR_BYTES)) ? wbase + 16'(BYTES) : wbase;
                        len     <= len_sum[16] ? 16'hFFFF : len_sum[15:0];
                        if (end_of_packet_i) begin
                            bus_ready_o   <= 1'b0;
                            pay_last_word <= masked;
                            st            <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    lim <= (len < 16'(HDR_BYTES)) ? len : 16'(HDR_BYTES);
                    off <= '0;  stk <= '0;  err <= '0;  vc <= '0;  gtp_e <= 1'b0;
                    st  <= S_ETH;
                end
                S_ETH, S_VLAN: begin
                    if (st == S_VLAN && vc == 8'(VLAN_MAX)) begin
                        err[2] <= 1'b1;  st <= S_DONE;
                    end else if (!fits(eth_len)) begin
                        err[0] <= 1'b1;  st <= S_DONE;
                    end else begin
                        if (st == S_ETH) stk[0] <= 1'b1;
                        else begin stk[1] <= 1'b1;  vc <= vc + 8'd1; end
                        off <= off + eth_len;
                        if (et == 16'h8100)      st <= S_VLAN;
                        else if (et == 16'h0800) st <= S_IPV4;
                        else begin stk[10] <= 1'b1;  st <= S_DONE; end
                    end
                end
                S_IPV4, S_IN_IPV4: begin
                    if (!fits(16'd20)) begin
                        err[0] <= 1'b1;  st <= S_DONE;
                    end else if (b0[7:4] != 4'd4 || b0[3:0] < 4'd5) begin
                        err[1] <= 1'b1;  st <= S_DONE;
                    end else if (!fits(ihl_len)) begin
                        err[0] <= 1'b1;  st <= S_DONE;
                    end else begin
                        stk[inner ? 7 : 2] <= 1'b1;
                        off   <= off + ihl_len;
                        proto <= b9;
                        if (b9 == 8'd17 || b9 == 8'd6) st <= inner ? S_IN_L4 : S_L4;
                        else begin stk[10] <= 1'b1;  st <= S_DONE; end
                    end
                end
                S_L4, S_IN_L4: begin
                    st <= S_DONE;
                    if (proto == 8'd17) begin
                        if (!fits(16'd8)) err[0] <= 1'b1;
                        else begin
                            stk[inner ? 8 : 3] <= 1'b1;
                            off <= off + 16'd8;
                            if (!inner && {b2, b3} == 16'(GTP_PORT)) st <= S_GTP;
                        end
                    end else begin
                        if (!fits(16'd20))       err[0] <= 1'b1;
                        else if (tcp_len < 16'd20) err[1] <= 1'b1;
                        else if (!fits(tcp_len)) err[0] <= 1'b1;
                        else begin
                            stk[inner ? 9 : 4] <= 1'b1;
                            off <= off + tcp_len;
                        end
                    end
                end
                S_GTP: begin
                    st <= S_DONE;
                    if (!fits(16'd8))             err[0] <= 1'b1;
                    else if (b0[7:5] != 3'd1)     err[1] <= 1'b1;
                    else begin
                        stk[5] <= 1'b1;
                        off    <= off + 16'd8;
                        gtp_e  <= b0[2];
                        if (b0[2:0] != 3'd0) st <= S_GTP_OPT;
                    end
                end
                S_GTP_OPT: begin
                    st <= S_DONE;
                    if (!fits(16'd4)) err[0] <= 1'b1;
                    else begin
                        off <= off + 16'd4;
                        if (gtp_e && b3 == 8'h85) st <= S_PDU;
                    end
                end
                S_PDU: begin
                    st <= S_DONE;
                    if (!fits(16'd1))          err[0] <= 1'b1;
                    else if (b0 == 8'd0)       err[1] <= 1'b1;
                    else if (!fits(pdu_len))   err[0] <= 1'b1;
                    else if (pdu_nx != 8'd0)   err[1] <= 1'b1;
                    else begin
                        stk[6] <= 1'b1;
                        off    <= off + pdu_len;
                        // A T-PDU cut off by the capture limit is left for the inner IPv4 check to flag.
                        if (!fits(pdu_len + 16'd1) || (tpdu & 8'hF0) == 8'h40) st <= S_IN_IPV4;
                        else stk[10] <= 1'b1;
                    end
                end
                S_DONE: begin
                    phs_o       <= stk;
                    pay_off_o   <= off;
                    pkt_len_o   <= len;
                    err_o       <= err;
                    phs_valid_o <= 1'b1;
                    st          <= S_CAP;
                end
                default: st <= S_CAP;
            endcase
        end
    end
endmodule

// File: tb/tb_packet_parser_gen.sv
// Scoreboard bench for packet_parser_gen at BUS_W=32 and BUS_W=64.
module tb_packet_parser_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] d32;  logic v32, sop32, eop32;  logic [1:0] eb32;
    logic        rdy32, pv32;  logic [15:0] phs32, off32, len32;  logic [2:0] err32;  logic [31:0] lw32;
    logic [63:0] d64;  logic v64, sop64, eop64;  logic [2:0] eb64;
    logic        rdy64, pv64;  logic [15:0] phs64, off64, len64;  logic [2:0] err64;  logic [63:0] lw64;

    packet_parser_gen #(.BUS_W(32)) dut32 (
        .CLK(clk), .reset(rst_n), .bus(d32), .bus_valid_i(v32), .start_of_packet_i(sop32),
        .end_of_packet_i(eop32), .eop_bytes_i(eb32), .bus_ready_o(rdy32), .phs_o(phs32),
        .phs_valid_o(pv32), .pay_off_o(off32), .pkt_len_o(len32), .err_o(err32), .pay_last_word(lw32));
    packet_parser_gen #(.BUS_W(64)) dut64 (
        .CLK(clk), .reset(rst_n), .bus(d64), .bus_valid_i(v64), .start_of_packet_i(sop64),
        .end_of_packet_i(eop64), .eop_bytes_i(eb64), .bus_ready_o(rdy64), .phs_o(phs64),
        .phs_valid_o(pv64), .pay_off_o(off64), .pkt_len_o(len64), .err_o(err64), .pay_last_word(lw64));

    typedef struct {
        logic [15:0]  phs;
        logic [15:0]  off;
        logic [15:0]  len;
        logic [2:0]   err;
        logic [127:0] lw;
        int           lat;
        int           eop_cyc;
    } exp_t;

    exp_t       q32[$], q64[$];
    exp_t       e32, e64;
    logic [7:0] pkt[$];
    int         total = 0, bad = 0, cyc = 0, last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s", nm);
    endtask

    task automatic add_eth(input logic [15:0] et);
        for (int i = 0; i < 12; i++) pkt.push_back(8'(8'h10 + i));
        pkt.push_back(et[15:8]);  pkt.push_back(et[7:0]);
    endtask
    task automatic add_vlan(input logic [15:0] nxt);
        pkt.push_back(8'h00);  pkt.push_back(8'h05);
        pkt.push_back(nxt[15:8]);  pkt.push_back(nxt[7:0]);
    endtask
    task automatic add_ipv4(input int ver, input int ihl, input logic [7:0] proto);
        int hl = ((ihl < 5) ? 5 : ihl) * 4;
        pkt.push_back({4'(ver), 4'(ihl)});
        for (int i = 1; i < 9; i++) pkt.push_back(8'(8'h30 + i));
        pkt.push_back(proto);
        for (int i = 10; i < hl; i++) pkt.push_back(8'(8'h30 + i));
    endtask
    task automatic add_udp(input logic [15:0] dport);
        pkt.push_back(8'h12);  pkt.push_back(8'h34);
        pkt.push_back(dport[15:8]);  pkt.push_back(dport[7:0]);
        pkt.push_back(8'h00);  pkt.push_back(8'h10);  pkt.push_back(8'h00);  pkt.push_back(8'h00);
    endtask
    task automatic add_tcp(input int doff);
        int hl = ((doff < 5) ? 5 : doff) * 4;
        for (int i = 0; i < 12; i++) pkt.push_back(8'(8'h50 + i));
        pkt.push_back({4'(doff), 4'h0});
        for (int i = 13; i < hl; i++) pkt.push_back(8'(8'h50 + i));
    endtask
    task automatic add_gtp(input logic [7:0] flags, input logic [7:0] nxt);
        pkt.push_back(flags);  pkt.push_back(8'hFF);  pkt.push_back(8'h00);  pkt.push_back(8'h40);
        for (int i = 0; i < 4; i++) pkt.push_back(8'(8'h20 + i));
        if (flags[2:0] != 3'd0) begin
            pkt.push_back(8'h00);  pkt.push_back(8'h00);  pkt.push_back(8'h00);  pkt.push_back(nxt);
        end
    endtask
    task automatic add_pdu(input int l);
        pkt.push_back(8'(l));
        for (int i = 1; i < l * 4 - 1; i++) pkt.push_back(8'h09);
        pkt.push_back(8'h00);
    endtask
    task automatic add_data(input int n);
        for (int i = 0; i < n; i++) pkt.push_back(8'(8'hA0 + i));
    endtask

    function automatic logic rdy(input int w);
        return (w == 32) ? rdy32 : rdy64;
    endfunction

    // Sends pkt as words; max_words > 0 sends only that many words and no EOP.
    task automatic send(input int w, input int max_words);
        int nb = w / 8;
        int n = pkt.size();
        int nw = (n + nb - 1) / nb;
        int lim;
        int guard;
        logic [127:0] word;
        lim = (max_words > 0 && max_words < nw) ? max_words : nw;
        for (int k = 0; k < lim; k++) begin
            word = '0;
            for (int j = 0; j < nb; j++)
                word[w-1-8*j -: 8] = (k * nb + j < n) ? pkt[k * nb + j] : 8'hEE;
            if (w == 32) begin
                d32 = word[31:0];  v32 = 1'b1;  sop32 = (k == 0);  eop32 = (k == nw - 1);  eb32 = 2'(n % 4);
            end else begin
                d64 = word[63:0];  v64 = 1'b1;  sop64 = (k == 0);  eop64 = (k == nw - 1);  eb64 = 3'(n % 8);
            end
            guard = 0;
            while (!rdy(w) && guard < 100) begin
                @(posedge clk); #1;
                guard++;
            end
            if (guard >= 100) begin
                fail("ready_timeout");
                break;
            end
            @(posedge clk); #1;
            last_acc = cyc;
        end
        v32 = 1'b0;  sop32 = 1'b0;  eop32 = 1'b0;
        v64 = 1'b0;  sop64 = 1'b0;  eop64 = 1'b0;
    endtask

    task automatic push_exp(input int w, input logic [15:0] phs, input logic [15:0] off,
                            input logic [2:0] err, input int lat);
        exp_t e;
        int nb = w / 8;
        int n = pkt.size();
        int base = ((n + nb - 1) / nb - 1) * nb;
        e.phs = phs;  e.off = off;  e.len = 16'(n);  e.err = err;  e.lat = lat;  e.eop_cyc = last_acc;
        e.lw = '0;
        for (int j = 0; j < nb; j++)
            if (base + j < n) e.lw[w-1-8*j -: 8] = pkt[base + j];
        if (w == 32) q32.push_back(e);
        else q64.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && (q32.size() != 0 || q64.size() != 0); i++) @(posedge clk);
        #1;
        chk("drain_pending", q32.size() + q64.size(), 0);
    endtask

    always @(negedge clk) begin
        if (pv32) begin
            if (q32.size() == 0) fail("unexpected_strobe32");
            else begin
                e32 = q32.pop_front();
                chk("phs32", phs32, e32.phs);
                chk("payoff32", off32, e32.off);
                chk("pktlen32", len32, e32.len);
                chk("err32", err32, e32.err);
                chk("lastword32", lw32, e32.lw);
                chk("ready_low32", rdy32, 0);
                if (e32.lat >= 0) chk("latency32", cyc - e32.eop_cyc, e32.lat);
            end
        end
    end

    always @(negedge clk) begin
        if (pv64) begin
            if (q64.size() == 0) fail("unexpected_strobe64");
            else begin
                e64 = q64.pop_front();
                chk("phs64", phs64, e64.phs);
                chk("payoff64", off64, e64.off);
                chk("pktlen64", len64, e64.len);
                chk("err64", err64, e64.err);
                chk("lastword64", lw64, e64.lw);
                chk("ready_low64", rdy64, 0);
                if (e64.lat >= 0) chk("latency64", cyc - e64.eop_cyc, e64.lat);
            end
        end
    end

    task automatic build_t1();
        pkt.delete();
        add_eth(16'h0800);  add_ipv4(4, 5, 8'd17);  add_udp(16'd53);  add_data(15);
    endtask
    task automatic build_t2();
        pkt.delete();
        add_eth(16'h0800);  add_ipv4(4, 7, 8'd17);  add_udp(16'd2152);  add_gtp(8'h34, 8'h85);
        add_pdu(1);  add_ipv4(4, 5, 8'd6);  add_tcp(8);  add_data(12);
    endtask

    initial begin
        rst_n = 1'b0;
        d32 = '0;  v32 = 1'b0;  sop32 = 1'b0;  eop32 = 1'b0;  eb32 = '0;
        d64 = '0;  v64 = 1'b0;  sop64 = 1'b0;  eop64 = 1'b0;  eb64 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready32", rdy32, 1);
        chk("reset_valid32", pv32, 0);
        chk("reset_phs32", phs32, 0);
        chk("reset_payoff32", off32, 0);
        chk("reset_pktlen32", len32, 0);
        chk("reset_err32", err32, 0);
        chk("reset_lastword32", lw32, 0);
        chk("reset_ready64", rdy64, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        build_t1();  send(32, 0);  push_exp(32, 16'h000D, 16'd42, 3'b000, 5);
        build_t2();  send(32, 0);  push_exp(32, 16'h02ED, 16'd118, 3'b000, -1);

        pkt.delete();  add_eth(16'h0800);  add_ipv4(4, 5, 8'd17);
        while (pkt.size() > 30) void'(pkt.pop_back());
        send(32, 0);  push_exp(32, 16'h0001, 16'd14, 3'b001, -1);

        pkt.delete();  add_eth(16'h0800);  add_ipv4(6, 5, 8'd17);  add_udp(16'd53);  add_data(10);
        send(32, 0);  push_exp(32, 16'h0001, 16'd14, 3'b010, -1);

        pkt.delete();  add_eth(16'h8100);  add_vlan(16'h8100);  add_vlan(16'h8100);  add_vlan(16'h0800);
        add_ipv4(4, 5, 8'd17);  add_data(8);
        send(32, 0);  push_exp(32, 16'h0003, 16'd22, 3'b100, -1);

        pkt.delete();  add_eth(16'h86DD);  add_data(40);
        send(32, 0);  push_exp(32, 16'h0401, 16'd14, 3'b000, -1);

        pkt.delete();  add_eth(16'h0800);  add_ipv4(4, 5, 8'd6);  add_tcp(3);  add_data(10);
        send(32, 0);  push_exp(32, 16'h0005, 16'd34, 3'b010, -1);

        pkt.delete();  add_eth(16'h0800);  add_ipv4(4, 5, 8'd1);  add_data(20);
        send(32, 0);  push_exp(32, 16'h0405, 16'd34, 3'b000, -1);

        pkt.delete();  add_eth(16'h8100);  add_vlan(16'h0800);  add_ipv4(4, 5, 8'd6);  add_tcp(5);  add_data(4);
        send(64, 0);  push_exp(64, 16'h0017, 16'd58, 3'b000, -1);
        build_t1();  send(64, 0);  push_exp(64, 16'h000D, 16'd42, 3'b000, 5);

        // Abandoned partial packet, then a fresh SOP: only the second is reported.
        pkt.delete();  add_eth(16'h86DD);  add_data(40);
        send(32, 3);
        build_t1();  send(32, 0);  push_exp(32, 16'h000D, 16'd42, 3'b000, 5);
        drain();

        build_t2();  send(32, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midwalk_reset_ready32", rdy32, 1);
        chk("midwalk_reset_phs32", phs32, 0);
        chk("midwalk_reset_valid32", pv32, 0);
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        build_t1();  send(32, 0);  push_exp(32, 16'h000D, 16'd42, 3'b000, 5);
        drain();
        repeat (5) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
